// File: rtl/rx_store_ctrl.sv
// Frame-level sequencer for the Ethernet RX data store: gates PHY beats in, waits for the
// CRC verdict, drains good frames to the consumer and clears the store between frames.
module rx_store_ctrl #(
    parameter int N             = 2,
    parameter int GAP_CYCLES    = 4,
    parameter int MIN_BEATS     = 32,
    parameter int CRC_TIMEOUT   = 64,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         phy_axiiv,
    input  logic [N-1:0] phy_axiid,
    input  logic         crc_done,
    input  logic         crc_ok,
    input  logic         consumer_ready,
    input  logic         store_axiov,
    output logic         store_axiiv,
    output logic [N-1:0] store_axiid,
    output logic         store_rst,
    output logic         store_read_request,
    output logic         frame_done,
    output logic         frame_drop,
    output logic [7:0]   frames_ok,
    output logic [7:0]   frames_dropped,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RECV     = 3'd1,
        WAIT_CRC = 3'd2,
        DRAIN    = 3'd3,
        CLEAR    = 3'd4
    } state_t;

    localparam int TMO_MAX = (CRC_TIMEOUT > DRAIN_TIMEOUT) ? CRC_TIMEOUT : DRAIN_TIMEOUT;
    localparam int TMO_W   = $clog2(TMO_MAX) + 1;
    localparam logic [TMO_W-1:0] CRC_LIM   = TMO_W'(CRC_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] DRAIN_LIM = TMO_W'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t             state, state_nxt;
    logic               prev_v;
    logic [15:0]        beat_cnt;
    logic [3:0]         gap_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               crc_seen, crc_ok_l;
    logic               pass_held;
    logic               prev_axiov;
    logic               clr_cnt;

    logic               rise, fwd, hold_set, done_ev, drop_ev;
    logic               verdict_ok, len_ok;

    always_comb begin
        state_nxt  = state;
        fwd        = 1'b0;
        hold_set   = 1'b0;
        done_ev    = 1'b0;
        drop_ev    = 1'b0;
        rise       = phy_axiiv & ~prev_v;
        verdict_ok = crc_seen ? crc_ok_l : crc_ok;
        len_ok     = (32'(beat_cnt) >= MIN_BEATS);

        case (state)
            IDLE: begin
                if (rise) begin
                    fwd       = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                fwd = phy_axiiv;
                if (!phy_axiiv && gap_cnt == GAP_LAST)
                    state_nxt = WAIT_CRC;
            end
            WAIT_CRC: begin
                // Once a good verdict is held, only consumer_ready matters; no timeout.
                if (pass_held) begin
                    if (consumer_ready)
                        state_nxt = DRAIN;
                end else if (crc_done || crc_seen) begin
                    if (verdict_ok && len_ok) begin
                        if (consumer_ready)
                            state_nxt = DRAIN;
                        else
                            hold_set = 1'b1;
                    end else begin
                        drop_ev   = 1'b1;
                        state_nxt = CLEAR;
                    end
                end else if (tmo_cnt == CRC_LIM) begin
                    drop_ev   = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            DRAIN: begin
                // prev_axiov is only ever set while draining, so it implies "seen high".
                if (prev_axiov && !store_axiov) begin
                    done_ev   = 1'b1;
                    state_nxt = CLEAR;
                end else if (tmo_cnt == DRAIN_LIM) begin
                    drop_ev   = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Internal sequencing state. prev_v resets high so a stream already running
    // at reset release cannot open a frame without a fresh low->high transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev_v     <= 1'b1;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            tmo_cnt    <= '0;
            crc_seen   <= 1'b0;
            crc_ok_l   <= 1'b0;
            pass_held  <= 1'b0;
            prev_axiov <= 1'b0;
            clr_cnt    <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_v     <= phy_axiiv;
            prev_axiov <= (state == DRAIN) ? store_axiov : 1'b0;
            clr_cnt    <= (state == CLEAR) ? ~clr_cnt : 1'b0;
            pass_held  <= (state == WAIT_CRC) && (state_nxt == WAIT_CRC) && (pass_held || hold_set);

            if (state == IDLE && rise)
                beat_cnt <= 16'd1;
            else if (state == RECV && phy_axiiv && beat_cnt != 16'hFFFF)
                beat_cnt <= beat_cnt + 16'd1;

            if (state == RECV && !phy_axiiv)
                gap_cnt <= gap_cnt + 4'd1;
            else
                gap_cnt <= '0;

            if (state == RECV) begin
                if (crc_done) begin
                    crc_seen <= 1'b1;
                    crc_ok_l <= crc_ok;
                end
            end else begin
                crc_seen <= 1'b0;
            end

            if (state_nxt != state || pass_held || !(state == WAIT_CRC || state == DRAIN))
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Registered outputs, all derived from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_axiiv        <= 1'b0;
            store_axiid        <= '0;
            store_rst          <= 1'b1;
            store_read_request <= 1'b0;
            frame_done         <= 1'b0;
            frame_drop         <= 1'b0;
            frames_ok          <= '0;
            frames_dropped     <= '0;
            busy               <= 1'b0;
        end else begin
            store_axiiv        <= fwd;
            store_axiid        <= fwd ? phy_axiid : '0;
            store_rst          <= (state_nxt == CLEAR);
            store_read_request <= (state_nxt == DRAIN);
            frame_done         <= done_ev;
            frame_drop         <= drop_ev;
            busy               <= (state_nxt != IDLE);
            if (done_ev && frames_ok != 8'hFF)
                frames_ok <= frames_ok + 8'd1;
            if (drop_ev && frames_dropped != 8'hFF)
                frames_dropped <= frames_dropped + 8'd1;
        end
    end

endmodule

// File: tb/tb_rx_store_ctrl.sv
// Directed bench for rx_store_ctrl: good/bad/runt frames, backpressure, timeouts,
// mid-frame reset and counter saturation.
module tb_rx_store_ctrl;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         phy_axiiv = 1'b0;
    logic [N-1:0] phy_axiid = '0;
    logic         crc_done = 1'b0;
    logic         crc_ok = 1'b0;
    logic         consumer_ready = 1'b0;
    logic         store_axiov = 1'b0;
    logic         store_axiiv;
    logic [N-1:0] store_axiid;
    logic         store_rst;
    logic         store_read_request;
    logic         frame_done;
    logic         frame_drop;
    logic [7:0]   frames_ok;
    logic [7:0]   frames_dropped;
    logic         busy;

    int checks = 0;
    int fails  = 0;

    // Monitor totals, only ever written by the monitor process.
    int fwd_cnt = 0, fwd_bad = 0, rr_cnt = 0, drop_cnt = 0, done_cnt = 0;
    logic [N-1:0] last_phy_d = '0;

    always #5 clk = ~clk;

    rx_store_ctrl #(
        .N(2), .GAP_CYCLES(4), .MIN_BEATS(32), .CRC_TIMEOUT(64), .DRAIN_TIMEOUT(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .phy_axiiv(phy_axiiv), .phy_axiid(phy_axiid),
        .crc_done(crc_done), .crc_ok(crc_ok),
        .consumer_ready(consumer_ready), .store_axiov(store_axiov),
        .store_axiiv(store_axiiv), .store_axiid(store_axiid),
        .store_rst(store_rst), .store_read_request(store_read_request),
        .frame_done(frame_done), .frame_drop(frame_drop),
        .frames_ok(frames_ok), .frames_dropped(frames_dropped),
        .busy(busy)
    );

    // Inputs change 2ns after posedge; at negedge the store outputs reflect the phy
    // value recorded at the previous negedge.
    always @(negedge clk) begin
        if (store_axiiv) begin
            fwd_cnt = fwd_cnt + 1;
            if (store_axiid !== last_phy_d) fwd_bad = fwd_bad + 1;
        end
        if (store_read_request) rr_cnt = rr_cnt + 1;
        if (frame_drop) drop_cnt = drop_cnt + 1;
        if (frame_done) done_cnt = done_cnt + 1;
        last_phy_d = phy_axiid;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_beats(input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            phy_axiiv = 1'b1;
            phy_axiid = N'(i * 3 + seed);
            cyc(1);
        end
        phy_axiiv = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        cyc(3);
        checks++; if (store_rst !== 1'b1) begin fails++; $display("FAIL reset store_rst: got %b want 1", store_rst); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (store_axiiv !== 1'b0 || store_read_request !== 1'b0) begin fails++; $display("FAIL reset axiiv/rreq: got %b/%b want 0/0", store_axiiv, store_read_request); end
        checks++; if (frames_ok !== 8'd0 || frames_dropped !== 8'd0) begin fails++; $display("FAIL reset counters: got %0d/%0d want 0/0", frames_ok, frames_dropped); end
        checks++; if (frame_done !== 1'b0 || frame_drop !== 1'b0) begin fails++; $display("FAIL reset pulses: got %b/%b want 0/0", frame_done, frame_drop); end
        rst_n = 1'b1;
        cyc(1);
        checks++; if (store_rst !== 1'b0) begin fails++; $display("FAIL release store_rst: got %b want 0", store_rst); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL release busy: got %b want 0", busy); end
        cyc(2);
    endtask

    task automatic test_good_frame;
        int f0, b0, r0;
        consumer_ready = 1'b1;
        cyc(2);
        f0 = fwd_cnt; b0 = fwd_bad;
        send_beats(64, 1);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL good busy in recv: got %b want 1", busy); end
        cyc(4);
        checks++; if (store_read_request !== 1'b0) begin fails++; $display("FAIL good rreq before crc: got %b want 0", store_read_request); end
        crc_done = 1'b1; crc_ok = 1'b1;
        cyc(1);
        crc_done = 1'b0; crc_ok = 1'b0;
        checks++; if (store_read_request !== 1'b1) begin fails++; $display("FAIL good rreq after crc: got %b want 1", store_read_request); end
        checks++; if (fwd_cnt - f0 !== 64) begin fails++; $display("FAIL good beat count: got %0d want 64", fwd_cnt - f0); end
        checks++; if (fwd_bad - b0 !== 0) begin fails++; $display("FAIL good beat data: got %0d bad want 0", fwd_bad - b0); end
        r0 = rr_cnt;
        store_axiov = 1'b1;
        cyc(10);
        store_axiov = 1'b0;
        cyc(1);
        checks++; if (rr_cnt - r0 !== 11) begin fails++; $display("FAIL good rreq cycles: got %0d want 11", rr_cnt - r0); end
        checks++; if (frame_done !== 1'b1 || store_rst !== 1'b1 || store_read_request !== 1'b0) begin fails++; $display("FAIL good end done/rst/rreq: got %b/%b/%b want 1/1/0", frame_done, store_rst, store_read_request); end
        checks++; if (frames_ok !== 8'd1) begin fails++; $display("FAIL good frames_ok: got %0d want 1", frames_ok); end
        cyc(1);
        checks++; if (frame_done !== 1'b0 || store_rst !== 1'b1) begin fails++; $display("FAIL good clear2 done/rst: got %b/%b want 0/1", frame_done, store_rst); end
        cyc(1);
        checks++; if (store_rst !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL good idle rst/busy: got %b/%b want 0/0", store_rst, busy); end
    endtask

    task automatic test_bad_crc;
        int f0, r0;
        cyc(2);
        r0 = rr_cnt;
        send_beats(64, 2);
        cyc(4);
        crc_done = 1'b1; crc_ok = 1'b0;
        cyc(1);
        crc_done = 1'b0;
        checks++; if (frame_drop !== 1'b1 || store_rst !== 1'b1) begin fails++; $display("FAIL badcrc drop/rst: got %b/%b want 1/1", frame_drop, store_rst); end
        checks++; if (frames_dropped !== 8'd1) begin fails++; $display("FAIL badcrc frames_dropped: got %0d want 1", frames_dropped); end
        cyc(1);
        checks++; if (frame_drop !== 1'b0 || store_rst !== 1'b1) begin fails++; $display("FAIL badcrc clear2 drop/rst: got %b/%b want 0/1", frame_drop, store_rst); end
        // Rising edge coincides with CLEAR->IDLE: the whole burst must be ignored.
        f0 = fwd_cnt;
        for (int i = 0; i < 10; i++) begin
            phy_axiiv = 1'b1;
            phy_axiid = N'(i);
            cyc(1);
        end
        phy_axiiv = 1'b0;
        cyc(1);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL badcrc late edge busy: got %b want 0", busy); end
        checks++; if (fwd_cnt - f0 !== 0) begin fails++; $display("FAIL badcrc late edge fwd: got %0d want 0", fwd_cnt - f0); end
        checks++; if (rr_cnt - r0 !== 0) begin fails++; $display("FAIL badcrc rreq cycles: got %0d want 0", rr_cnt - r0); end
    endtask

    task automatic test_runt;
        int f0, r0;
        cyc(2);
        f0 = fwd_cnt; r0 = rr_cnt;
        send_beats(20, 3);
        cyc(4);
        crc_done = 1'b1; crc_ok = 1'b1;
        cyc(1);
        crc_done = 1'b0; crc_ok = 1'b0;
        checks++; if (frame_drop !== 1'b1) begin fails++; $display("FAIL runt drop: got %b want 1", frame_drop); end
        checks++; if (frames_dropped !== 8'd2) begin fails++; $display("FAIL runt frames_dropped: got %0d want 2", frames_dropped); end
        cyc(2);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL runt idle busy: got %b want 0", busy); end
        checks++; if (rr_cnt - r0 !== 0 || fwd_cnt - f0 !== 20) begin fails++; $display("FAIL runt rreq/fwd: got %0d/%0d want 0/20", rr_cnt - r0, fwd_cnt - f0); end
    endtask

    task automatic test_backpressure;
        int d0;
        consumer_ready = 1'b0;
        cyc(2);
        d0 = drop_cnt;
        send_beats(64, 0);
        cyc(4);
        crc_done = 1'b1; crc_ok = 1'b1;
        cyc(1);
        crc_done = 1'b0; crc_ok = 1'b0;
        cyc(199);
        checks++; if (store_read_request !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL bp hold rreq/busy: got %b/%b want 0/1", store_read_request, busy); end
        checks++; if (drop_cnt - d0 !== 0) begin fails++; $display("FAIL bp no timeout: got %0d drops want 0", drop_cnt - d0); end
        consumer_ready = 1'b1;
        cyc(1);
        checks++; if (store_read_request !== 1'b1) begin fails++; $display("FAIL bp drain start: got %b want 1", store_read_request); end
        store_axiov = 1'b1;
        cyc(3);
        store_axiov = 1'b0;
        cyc(1);
        checks++; if (frame_done !== 1'b1 || frames_ok !== 8'd2) begin fails++; $display("FAIL bp done/frames_ok: got %b/%0d want 1/2", frame_done, frames_ok); end
        cyc(2);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL bp idle busy: got %b want 0", busy); end
    endtask

    task automatic test_crc_timeout;
        cyc(2);
        send_beats(40, 1);
        cyc(4);
        cyc(63);
        checks++; if (frame_drop !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL crctmo early drop/busy: got %b/%b want 0/1", frame_drop, busy); end
        cyc(1);
        checks++; if (frame_drop !== 1'b1 || frames_dropped !== 8'd3) begin fails++; $display("FAIL crctmo drop/count: got %b/%0d want 1/3", frame_drop, frames_dropped); end
        cyc(2);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL crctmo idle busy: got %b want 0", busy); end
    endtask

    task automatic test_drain_timeout;
        cyc(2);
        send_beats(40, 2);
        cyc(4);
        crc_done = 1'b1; crc_ok = 1'b1;
        cyc(1);
        crc_done = 1'b0; crc_ok = 1'b0;
        store_axiov = 1'b1;
        cyc(1023);
        checks++; if (frame_drop !== 1'b0 || store_read_request !== 1'b1) begin fails++; $display("FAIL draintmo early drop/rreq: got %b/%b want 0/1", frame_drop, store_read_request); end
        cyc(1);
        checks++; if (frame_drop !== 1'b1 || store_read_request !== 1'b0 || store_rst !== 1'b1) begin fails++; $display("FAIL draintmo drop/rreq/rst: got %b/%b/%b want 1/0/1", frame_drop, store_read_request, store_rst); end
        checks++; if (frames_dropped !== 8'd4 || frames_ok !== 8'd2) begin fails++; $display("FAIL draintmo counters: got %0d/%0d want 4/2", frames_dropped, frames_ok); end
        store_axiov = 1'b0;
        cyc(2);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL draintmo idle busy: got %b want 0", busy); end
    endtask

    task automatic test_midframe_reset;
        int f0;
        cyc(2);
        for (int i = 0; i < 10; i++) begin
            phy_axiiv = 1'b1;
            phy_axiid = N'(i);
            cyc(1);
        end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst busy before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || store_axiiv !== 1'b0 || store_rst !== 1'b1) begin fails++; $display("FAIL midrst async busy/axiiv/rst: got %b/%b/%b want 0/0/1", busy, store_axiiv, store_rst); end
        checks++; if (frames_ok !== 8'd0 || frames_dropped !== 8'd0) begin fails++; $display("FAIL midrst counters: got %0d/%0d want 0/0", frames_ok, frames_dropped); end
        cyc(2);
        rst_n = 1'b1;
        f0 = fwd_cnt;
        for (int i = 0; i < 6; i++) begin
            phy_axiid = N'(i + 1);
            cyc(1);
        end
        checks++; if (fwd_cnt - f0 !== 0 || busy !== 1'b0) begin fails++; $display("FAIL midstart fwd/busy: got %0d/%b want 0/0", fwd_cnt - f0, busy); end
        phy_axiiv = 1'b0;
        cyc(1);
        // 10 beats, a GAP_CYCLES-1 idle hole, then 30 beats: one 40-beat frame.
        f0 = fwd_cnt;
        for (int i = 0; i < 10; i++) begin
            phy_axiiv = 1'b1;
            phy_axiid = N'(i * 5);
            cyc(1);
        end
        phy_axiiv = 1'b0;
        cyc(3);
        send_beats(30, 1);
        cyc(4);
        checks++; if (fwd_cnt - f0 !== 40 || busy !== 1'b1) begin fails++; $display("FAIL gap fwd/busy: got %0d/%b want 40/1", fwd_cnt - f0, busy); end
        crc_done = 1'b1; crc_ok = 1'b1;
        cyc(1);
        crc_done = 1'b0; crc_ok = 1'b0;
        checks++; if (store_read_request !== 1'b1) begin fails++; $display("FAIL gap accept rreq: got %b want 1", store_read_request); end
        store_axiov = 1'b1;
        cyc(2);
        store_axiov = 1'b0;
        cyc(1);
        checks++; if (frames_ok !== 8'd1 || frames_dropped !== 8'd0) begin fails++; $display("FAIL gap counters: got %0d/%0d want 1/0", frames_ok, frames_dropped); end
        cyc(2);
    endtask

    task automatic test_saturation;
        cyc(2);
        for (int k = 1; k <= 300; k++) begin
            send_beats(1, k);
            cyc(4);
            crc_done = 1'b1; crc_ok = 1'b0;
            cyc(1);
            crc_done = 1'b0;
            cyc(2);
            if (k == 254) begin
                checks++; if (frames_dropped !== 8'd254) begin fails++; $display("FAIL sat at 254: got %0d want 254", frames_dropped); end
            end
            if (k == 255) begin
                checks++; if (frames_dropped !== 8'd255) begin fails++; $display("FAIL sat at 255: got %0d want 255", frames_dropped); end
            end
        end
        checks++; if (frames_dropped !== 8'd255 || frames_ok !== 8'd1) begin fails++; $display("FAIL sat final: got %0d/%0d want 255/1", frames_dropped, frames_ok); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL sat idle busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_runt();
        test_backpressure();
        test_crc_timeout();
        test_drain_timeout();
        test_midframe_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rx_store_ctrl.md
# rx_store_ctrl

Frame-level sequencer for the Ethernet receive data store. It gates the incoming N-bit PHY stream into the store, waits for the CRC verdict at frame end, then drains good frames to the downstream packet consumer by holding the store's read request. It clears the store between frames, drops bad or short frames, and keeps saturating good/dropped frame counters for the debug display.

## Interface

Parameters:
- N, 2, PHY beat width; must divide 16.
- GAP_CYCLES, 4, consecutive idle (phy_axiiv=0) cycles that end a frame; range 1..15.
- MIN_BEATS, 32, minimum forwarded beats for a frame to be accepted.
- CRC_TIMEOUT, 64, cycles allowed in WAIT_CRC before the frame is dropped.
- DRAIN_TIMEOUT, 1024, cycles allowed in DRAIN before it is forcibly ended.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- phy_axiiv  in  1  upstream beat valid.
- phy_axiid  in  N  upstream beat data.
- crc_done  in  1  one-cycle pulse from the CRC checker at frame end.
- crc_ok  in  1  CRC verdict, sampled only when crc_done=1.
- consumer_ready  in  1  level; downstream can accept a frame.
- store_axiov  in  1  read-data valid from the store.
- store_axiiv  out  1  gated beat valid to the store.
- store_axiid  out  N  gated beat data to the store.
- store_rst  out  1  active-high synchronous clear for the store.
- store_read_request  out  1  held high for the entire drain.
- frame_done  out  1  one-cycle pulse when a good frame finishes draining.
- frame_drop  out  1  one-cycle pulse when a frame is discarded.
- frames_ok  out  8  saturating count of drained frames.
- frames_dropped  out  8  saturating count of dropped frames.
- busy  out  1  high in every state except IDLE.

## Operation

- States: IDLE, RECV, WAIT_CRC, DRAIN, CLEAR. All outputs are registered.
- IDLE:
  - Tracks prev_v, the registered phy_axiiv.
  - Entry to RECV requires a rising edge: phy_axiiv=1 and prev_v=0. This prevents a frame from starting partway through.
  - The rising-edge beat is forwarded; beat_cnt is set to 1.
- RECV:
  - store_axiiv/store_axiid follow phy_axiiv/phy_axiid, delayed by one register stage.
  - beat_cnt (16-bit) increments on each valid beat and saturates at 0xFFFF.
  - gap_cnt resets on each valid beat and increments on each idle cycle. When gap_cnt reaches GAP_CYCLES, go to WAIT_CRC.
  - A crc_done pulse that arrives while in RECV is latched and consumed in WAIT_CRC.
- WAIT_CRC:
  - On crc_done (live or latched), go to DRAIN only if crc_ok=1, beat_cnt ≥ MIN_BEATS and consumer_ready=1.
  - If crc_ok=1 and the length passes but consumer_ready=0, stay and wait for consumer_ready. The verdict is latched, and the CRC timeout no longer applies.
  - Otherwise, pulse frame_drop and go to CLEAR.
  - If CRC_TIMEOUT cycles pass with no crc_done, pulse frame_drop and go to CLEAR.
- DRAIN:
  - store_read_request=1.
  - Drain ends on the first falling edge of store_axiov after it has been seen high: pulse frame_done, then go to CLEAR.
  - DRAIN_TIMEOUT cycles without that edge ends the drain as a drop: pulse frame_drop, then go to CLEAR.
- CLEAR:
  - store_rst=1 and store_read_request=0 for exactly 2 cycles.
  - Then IDLE.
- Stream gating: phy beats outside RECV are discarded, so store_axiiv=0.
- Counters: frames_ok increments with frame_done and frames_dropped with frame_drop. Both hold at 255.

## Timing

- Reset (async assert, release synchronized to clk), values:
  - state=IDLE.
  - store_axiiv, store_read_request, frame_done, frame_drop and busy = 0.
  - store_rst=1 while rst_n=0; it is 0 from the first cycle after release.
  - store_axiid, frames_ok and frames_dropped = 0.
  - All internal counters = 0.
- Forwarding latency: phy beat at cycle t appears on store_axiiv/store_axiid at cycle t+1.
- Last beat at cycle t means WAIT_CRC is entered at t+GAP_CYCLES+1.
- crc_done at cycle t (with consumer_ready=1) means store_read_request=1 from t+1.
- store_axiov falling at cycle t means frame_done=1 and store_rst=1 at t+1, with IDLE at t+3.
- A phy rising edge in the same cycle as CLEAR→IDLE is ignored. That frame's later beats are also ignored, because no new rising edge occurs.
- rst_n asserted mid-frame or mid-drain: everything returns to reset values immediately, and the partial frame is not counted.

## Test plan

- Good frame, 64 beats: crc_done/crc_ok=1 five cycles after the last beat, consumer_ready=1.
  - Exactly 64 store_axiiv beats, each matching phy data one cycle late.
  - store_read_request is high until the store_axiov falling edge.
  - frame_done pulse; frames_ok=1; store_rst high for 2 cycles.
- Bad CRC: 64 beats, then crc_done with crc_ok=0.
  - No read request; frame_drop pulse; frames_dropped=1; CLEAR then IDLE.
- Runt frame: 20 beats with MIN_BEATS=32 and crc_ok=1.
  - Frame dropped; frames_dropped increments; store_read_request never asserts.
- Backpressure: good frame with consumer_ready=0 for 200 cycles after crc_done.
  - Stays in WAIT_CRC with no timeout.
  - DRAIN starts the cycle after consumer_ready rises.
- Mid-frame start and gap: phy_axiiv already high when leaving reset.
  - No forwarding until a low→high transition.
  - An idle gap of GAP_CYCLES−1 inside a frame does not end the frame.
- Timeouts and saturation:
  - No crc_done for 64 cycles leads to a drop.
  - store_axiov stuck high for 1024 cycles in DRAIN leads to a drop.
  - 300 consecutive dropped frames leave frames_dropped=255.
